// File: rtl/fib_engine.sv
// -----------------------------------------------------------------------------
// fib_engine
//   Computes the Fibonacci term F(n), with F(0)=0 and F(1)=1, using one merged
//   control/datapath block. A run can present only the final term (mode=0),
//   or stream every term F(0)..F(n), one per cycle (mode=1). Term values wrap
//   modulo 2^DATA_W. The overflow flag reports when the true value of a term
//   does not fit in DATA_W bits.
//
// Parameters
//   DATA_W    width of the term registers and of fib_out
//   IDX_W     width of the requested index and of the term counter
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      request a computation; ignored while busy
//   n_in       requested index n, latched on an accepted start
//   mode       0 = present final term only, 1 = stream all terms
//   busy       high while a computation is running
//   done       one-cycle pulse when F(n) is presented
//   out_valid  one-cycle pulse for each presented term
//   fib_out    presented term value, modulo 2^DATA_W
//   index_out  index k of the presented term
//   overflow   true value of the presented term is >= 2^DATA_W
// -----------------------------------------------------------------------------
module fib_engine #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  n_in,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic [DATA_W-1:0] fib_out,
  output logic [IDX_W-1:0]  index_out,
  output logic              overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  n_r;
  logic              mode_r;
  logic [IDX_W-1:0]  k;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] nxt;
  logic              ovf_cur;
  logic              ovf_nxt;

  // One extra bit captures the carry-out of the next-term addition.
  logic [DATA_W:0]   sum;
  logic              last_term;

  assign sum       = {1'b0, cur} + {1'b0, nxt};
  assign last_term = (k == n_r);

  // busy is a direct decode of the state register, so it is glitch-free
  // and exactly tracks the RUN cycles.
  assign busy = (state == RUN);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the value from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      n_r       <= '0;
      mode_r    <= 1'b0;
      k         <= '0;
      cur       <= '0;
      nxt       <= '0;
      ovf_cur   <= 1'b0;
      ovf_nxt   <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      fib_out   <= '0;
      index_out <= '0;
      overflow  <= 1'b0;
    end else begin
      // Pulses default low; they are raised only on presentation edges.
      done      <= 1'b0;
      out_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            n_r     <= n_in;
            mode_r  <= mode;
            k       <= '0;
            cur     <= '0;
            nxt     <= DATA_W'(1);
            ovf_cur <= 1'b0;
            ovf_nxt <= 1'b0;
            state   <= RUN;
          end
        end

        RUN: begin
          // Every RUN edge presents term k; the presented value registers
          // hold between runs because they are written nowhere else.
          fib_out   <= cur;
          index_out <= k;
          overflow  <= ovf_cur;
          out_valid <= mode_r | last_term;
          done      <= last_term;

          if (last_term) begin
            state <= IDLE;
          end else begin
            cur     <= nxt;
            nxt     <= sum[DATA_W-1:0];
            k       <= k + IDX_W'(1);
            ovf_cur <= ovf_nxt;
            // Sticky: once any term has overflowed, every later term is
            // also out of range, even though the wrapped sums may not carry.
            ovf_nxt <= ovf_cur | ovf_nxt | sum[DATA_W];
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_engine.sv
// -----------------------------------------------------------------------------
// tb_fib_engine
//   Directed self-checking bench for fib_engine (DATA_W=16, IDX_W=5).
//   Expected values are hand-computed Fibonacci terms.
// -----------------------------------------------------------------------------
module tb_fib_engine;

  localparam int DATA_W = 16;
  localparam int IDX_W  = 5;

  logic              clk;
  logic              reset;
  logic              start;
  logic [IDX_W-1:0]  n_in;
  logic              mode;
  logic              busy;
  logic              done;
  logic              out_valid;
  logic [DATA_W-1:0] fib_out;
  logic [IDX_W-1:0]  index_out;
  logic              overflow;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int check_cnt = 0;

  fib_engine #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .n_in      (n_in),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .fib_out   (fib_out),
    .index_out (index_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start request; returns 1 time unit after the accepting edge.
  task automatic do_start(input int n, input logic m);
    @(negedge clk);
    start = 1'b1;
    n_in  = IDX_W'(n);
    mode  = m;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for done; reports cycles waited and out_valid pulses seen.
  task automatic wait_done(input int limit, output int cyc, output int ov_cnt);
    cyc    = 0;
    ov_cnt = 0;
    do begin
      tick();
      cyc++;
      if (out_valid) ov_cnt++;
    end while (!done && cyc < limit);
  endtask

  int cyc;
  int ov;
  logic [DATA_W-1:0] stream_exp [6];

  initial begin
    stream_exp[0] = 16'd0;
    stream_exp[1] = 16'd1;
    stream_exp[2] = 16'd1;
    stream_exp[3] = 16'd2;
    stream_exp[4] = 16'd3;
    stream_exp[5] = 16'd5;

    reset = 1'b1;
    start = 1'b0;
    n_in  = '0;
    mode  = 1'b0;

    // Reset state
    #12;
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fib_out",   32'(fib_out),   32'd0);
    check("rst_index_out", 32'(index_out), 32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    @(negedge clk);
    reset = 1'b0;

    // n=0, mode 0: single RUN cycle presenting 0
    do_start(0, 1'b0);
    check("n0_busy_run", 32'(busy), 32'd1);
    check("n0_done_early", 32'(done), 32'd0);
    wait_done(10, cyc, ov);
    check("n0_latency",   32'(cyc),       32'd1);
    check("n0_done",      32'(done),      32'd1);
    check("n0_out_valid", 32'(out_valid), 32'd1);
    check("n0_fib_out",   32'(fib_out),   32'd0);
    check("n0_index_out", 32'(index_out), 32'd0);
    check("n0_overflow",  32'(overflow),  32'd0);
    check("n0_busy_end",  32'(busy),      32'd0);
    tick();
    check("n0_done_clear",  32'(done),      32'd0);
    check("n0_valid_clear", 32'(out_valid), 32'd0);

    // n=10, mode 0
    do_start(10, 1'b0);
    wait_done(40, cyc, ov);
    check("n10_latency",   32'(cyc),       32'd11);
    check("n10_valid_cnt", 32'(ov),        32'd1);
    check("n10_fib_out",   32'(fib_out),   32'd55);
    check("n10_index_out", 32'(index_out), 32'd10);
    check("n10_overflow",  32'(overflow),  32'd0);

    // Overflow boundary for DATA_W=16
    do_start(24, 1'b0);
    wait_done(40, cyc, ov);
    check("n24_latency",  32'(cyc),      32'd25);
    check("n24_fib_out",  32'(fib_out),  32'd46368);
    check("n24_overflow", 32'(overflow), 32'd0);

    do_start(25, 1'b0);
    wait_done(40, cyc, ov);
    check("n25_fib_out",  32'(fib_out),  32'd9489);
    check("n25_overflow", 32'(overflow), 32'd1);

    do_start(31, 1'b0);
    wait_done(40, cyc, ov);
    check("n31_latency",   32'(cyc),       32'd32);
    check("n31_fib_out",   32'(fib_out),   32'd35549);
    check("n31_index_out", 32'(index_out), 32'd31);
    check("n31_overflow",  32'(overflow),  32'd1);

    // Overflow clears on next start: n=1 after the overflowing run
    do_start(1, 1'b0);
    wait_done(10, cyc, ov);
    check("n1_fib_out",  32'(fib_out),  32'd1);
    check("n1_overflow", 32'(overflow), 32'd0);

    // n=5, mode 1: stream every term
    do_start(5, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("stream%0d_fib", i),   32'(fib_out),   32'(stream_exp[i]));
      check($sformatf("stream%0d_idx", i),   32'(index_out), 32'(i));
      check($sformatf("stream%0d_done", i),  32'(done),      32'(i == 5));
    end
    tick();
    check("stream_after_valid", 32'(out_valid), 32'd0);
    check("stream_after_done",  32'(done),      32'd0);
    check("stream_after_fib",   32'(fib_out),   32'd5);

    // Start during a run is ignored
    do_start(10, 1'b0);
    start = 1'b1;
    n_in  = IDX_W'(3);
    repeat (3) tick();
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    wait_done(40, cyc, ov);
    check("ign_latency",   32'(cyc),       32'd8);
    check("ign_fib_out",   32'(fib_out),   32'd55);
    check("ign_index_out", 32'(index_out), 32'd10);

    // Start in the done cycle is accepted (back-to-back)
    do_start(7, 1'b0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(40, cyc, ov);
    check("b2b_latency",   32'(cyc),       32'd8);
    check("b2b_fib_out",   32'(fib_out),   32'd13);
    check("b2b_index_out", 32'(index_out), 32'd7);

    // Asynchronous reset mid-run aborts with no done pulse
    do_start(20, 1'b0);
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_fib_out",   32'(fib_out),   32'd0);
    check("abort_index_out", 32'(index_out), 32'd0);
    check("abort_done",      32'(done),      32'd0);
    @(negedge clk);
    reset = 1'b0;
    ov = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) ov++;
    end
    check("abort_no_done", 32'(ov),   32'd0);
    check("abort_idle",    32'(busy), 32'd0);

    do_start(2, 1'b0);
    wait_done(10, cyc, ov);
    check("post_latency",   32'(cyc),       32'd3);
    check("post_fib_out",   32'(fib_out),   32'd1);
    check("post_index_out", 32'(index_out), 32'd2);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
